// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: datapath widths, write-back select codes and load funct3 encodings.
package riscv_pkg;

   localparam int XLEN         = 32;
   localparam int WB_SEL_WIDTH = 2;

   typedef enum logic [WB_SEL_WIDTH-1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2
   } wb_sel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_load_ext.sv
// Load-data alignment: shifts the raw memory word down to the addressed byte/half
// and sign- or zero-extends it according to the load funct3.
module wb_load_ext
   import riscv_pkg::*;
(
   input  logic [XLEN-1:0] mem_word,
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   output logic [XLEN-1:0] load_data
);

   logic [XLEN-1:0] byte_word;
   logic [XLEN-1:0] half_word;

   // Halfword loads are naturally aligned, so only the upper offset bit selects the half.
   assign byte_word = mem_word >> {addr_lo, 3'b000};
   assign half_word = mem_word >> {addr_lo[1], 4'b0000};

   // NOTE: a default assignment ahead of the case keeps every path driven, so no latch is inferred.
   always_comb begin
      load_data = mem_word;
      case (funct3)
         F3_LB:   load_data = {{(XLEN-8){byte_word[7]}}, byte_word[7:0]};
         F3_LH:   load_data = {{(XLEN-16){half_word[15]}}, half_word[15:0]};
         F3_LW:   load_data = mem_word;
         F3_LBU:  load_data = {{(XLEN-8){1'b0}}, byte_word[7:0]};
         F3_LHU:  load_data = {{(XLEN-16){1'b0}}, half_word[15:0]};
         default: load_data = mem_word;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// RV32I write-back stage: result mux, register-file write gating and WB->ID bypass registers.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage
   import riscv_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_wb,
   input  logic                    reg_write_wb,
   input  logic [4:0]              rd_wb,
   input  logic [XLEN-1:0]         alu_wb,
   input  logic [XLEN-1:0]         mem_wb,
   input  logic [XLEN-1:0]         pc_wb,
   input  logic [2:0]              funct3_wb,
   input  logic [1:0]              addr_lo_wb,
   input  logic [WB_SEL_WIDTH-1:0] wb_sel,
   output logic [XLEN-1:0]         reg_wb,
   output logic [4:0]              rd_out,
   output logic                    we_out,
   output logic [XLEN-1:0]         byp_data,
   output logic [4:0]              byp_rd,
`ifdef WB_RETIRE_CNT_EN
   output logic [63:0]             retired_cnt,
`endif
   output logic                    byp_we
);

   logic [XLEN-1:0] load_data;

   wb_load_ext u_load_ext (
      .mem_word  (mem_wb),
      .funct3    (funct3_wb),
      .addr_lo   (addr_lo_wb),
      .load_data (load_data)
   );

   // The reserved code and any unknown select fall to the default, so nothing undefined leaks out.
   always_comb begin
      reg_wb = '0;
      case (wb_sel)
         WB_ALU:  reg_wb = alu_wb;
         WB_MEM:  reg_wb = load_data;
         WB_PC4:  reg_wb = pc_wb + XLEN'(4);
         default: reg_wb = '0;
      endcase
   end

   assign rd_out = rd_wb;
   assign we_out = valid_wb & reg_write_wb & (rd_wb != 5'd0);

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byp_we   <= 1'b0;
         byp_rd   <= '0;
         byp_data <= '0;
      end else begin
         byp_we <= we_out;
         if (we_out) begin
            byp_rd   <= rd_wb;
            byp_data <= reg_wb;
         end
      end
   end

`ifdef WB_RETIRE_CNT_EN
   logic [63:0] retire_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_q <= '0;
      end else if (valid_wb) begin
         retire_q <= retire_q + 64'd1;
      end
   end

   assign retired_cnt = retire_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: table-driven vectors with a bypass scoreboard queue,
// plus hand-written reset sequences. Counter checks apply when WB_RETIRE_CNT_EN is defined.
module tb_wb_stage;

   logic        clk;
   logic        rst_n;
   logic        valid_wb;
   logic        reg_write_wb;
   logic [4:0]  rd_wb;
   logic [31:0] alu_wb;
   logic [31:0] mem_wb;
   logic [31:0] pc_wb;
   logic [2:0]  funct3_wb;
   logic [1:0]  addr_lo_wb;
   logic [1:0]  wb_sel;
   logic [31:0] reg_wb;
   logic [4:0]  rd_out;
   logic        we_out;
   logic [31:0] byp_data;
   logic [4:0]  byp_rd;
   logic        byp_we;
`ifdef WB_RETIRE_CNT_EN
   logic [63:0] retired_cnt;
`endif

   wb_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .valid_wb     (valid_wb),
      .reg_write_wb (reg_write_wb),
      .rd_wb        (rd_wb),
      .alu_wb       (alu_wb),
      .mem_wb       (mem_wb),
      .pc_wb        (pc_wb),
      .funct3_wb    (funct3_wb),
      .addr_lo_wb   (addr_lo_wb),
      .wb_sel       (wb_sel),
      .reg_wb       (reg_wb),
      .rd_out       (rd_out),
      .we_out       (we_out),
      .byp_data     (byp_data),
      .byp_rd       (byp_rd),
`ifdef WB_RETIRE_CNT_EN
      .retired_cnt  (retired_cnt),
`endif
      .byp_we       (byp_we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic        rw;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] mem;
      logic [31:0] pc;
      logic [2:0]  f3;
      logic [1:0]  off;
      logic [1:0]  sel;
      logic [31:0] exp_reg;
      logic        exp_we;
   } vec_t;

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [63:0] cnt;
   } byp_t;

   vec_t  vecs[$];
   byp_t  sb_q[$];
   int    n_checks = 0;
   int    n_errors = 0;

   logic        m_we;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   logic [63:0] m_cnt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic v, input logic rw, input logic [4:0] rd,
                               input logic [31:0] alu, input logic [31:0] mem,
                               input logic [31:0] pc, input logic [2:0] f3,
                               input logic [1:0] off, input logic [1:0] sel,
                               input logic [31:0] er, input logic ew);
      vec_t t;
      t.valid = v;   t.rw = rw;   t.rd = rd;   t.alu = alu; t.mem = mem;
      t.pc = pc;     t.f3 = f3;   t.off = off; t.sel = sel;
      t.exp_reg = er; t.exp_we = ew;
      return t;
   endfunction

   task automatic apply(input vec_t t, input string tag);
      byp_t exp_b;
      byp_t got;
      @(negedge clk);
      valid_wb     = t.valid;
      reg_write_wb = t.rw;
      rd_wb        = t.rd;
      alu_wb       = t.alu;
      mem_wb       = t.mem;
      pc_wb        = t.pc;
      funct3_wb    = t.f3;
      addr_lo_wb   = t.off;
      wb_sel       = t.sel;
      #1;
      check({tag, " reg_wb"}, 64'(reg_wb), 64'(t.exp_reg));
      check({tag, " we_out"}, 64'(we_out), 64'(t.exp_we));
      check({tag, " rd_out"}, 64'(rd_out), 64'(t.rd));
      // Expected bypass state after the coming edge, built from the vector's own expectations.
      m_we = t.exp_we;
      if (t.exp_we) begin
         m_rd   = t.rd;
         m_data = t.exp_reg;
      end
      if (t.valid) m_cnt = m_cnt + 64'd1;
      exp_b.we = m_we; exp_b.rd = m_rd; exp_b.data = m_data; exp_b.cnt = m_cnt;
      sb_q.push_back(exp_b);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      check({tag, " byp_we"},   64'(byp_we),   64'(got.we));
      check({tag, " byp_rd"},   64'(byp_rd),   64'(got.rd));
      check({tag, " byp_data"}, 64'(byp_data), 64'(got.data));
`ifdef WB_RETIRE_CNT_EN
      check({tag, " retired_cnt"}, retired_cnt, got.cnt);
`endif
   endtask

   task automatic model_reset();
      m_we = 1'b0; m_rd = '0; m_data = '0; m_cnt = '0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " byp_we"},   64'(byp_we),   64'(0));
      check({tag, " byp_rd"},   64'(byp_rd),   64'(0));
      check({tag, " byp_data"}, 64'(byp_data), 64'(0));
`ifdef WB_RETIRE_CNT_EN
      check({tag, " retired_cnt"}, retired_cnt, 64'(0));
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      w = 32'h8001_F280;
      vecs.push_back(mk(1, 1, 5'd1, 32'h0000_0000, w, 0, 3'b000, 2'd0, 2'd0, 32'h0000_0000, 1));
      vecs.push_back(mk(1, 1, 5'd2, 32'hFFFF_FFFF, w, 0, 3'b000, 2'd0, 2'd0, 32'hFFFF_FFFF, 1));
      vecs.push_back(mk(1, 1, 5'd3, 0, w, 0, 3'b000, 2'd0, 2'd1, 32'hFFFF_FF80, 1));
      vecs.push_back(mk(1, 1, 5'd3, 0, w, 0, 3'b100, 2'd0, 2'd1, 32'h0000_0080, 1));
      vecs.push_back(mk(1, 1, 5'd4, 0, w, 0, 3'b001, 2'd2, 2'd1, 32'hFFFF_8001, 1));
      vecs.push_back(mk(1, 1, 5'd4, 0, w, 0, 3'b101, 2'd2, 2'd1, 32'h0000_8001, 1));
      vecs.push_back(mk(1, 1, 5'd9, 0, w, 0, 3'b010, 2'd0, 2'd1, 32'h8001_F280, 1));
      vecs.push_back(mk(1, 1, 5'd9, 0, w, 0, 3'b001, 2'd3, 2'd1, 32'hFFFF_8001, 1));
      vecs.push_back(mk(1, 1, 5'd10, 0, w, 0, 3'b000, 2'd1, 2'd1, 32'hFFFF_FFF2, 1));
      vecs.push_back(mk(1, 1, 5'd10, 0, w, 0, 3'b100, 2'd3, 2'd1, 32'h0000_0080, 1));
      vecs.push_back(mk(1, 1, 5'd11, 0, w, 0, 3'b001, 2'd0, 2'd1, 32'hFFFF_F280, 1));
      vecs.push_back(mk(1, 1, 5'd11, 0, w, 0, 3'b011, 2'd1, 2'd1, 32'h8001_F280, 1));
      vecs.push_back(mk(1, 1, 5'd12, 0, 0, 32'hFFFF_FFFC, 3'b000, 2'd0, 2'd2, 32'h0000_0000, 1));
      vecs.push_back(mk(1, 1, 5'd13, 0, 0, 32'h0000_0100, 3'b000, 2'd0, 2'd2, 32'h0000_0104, 1));
      vecs.push_back(mk(1, 1, 5'd0, 32'h0000_1234, 0, 0, 3'b000, 2'd0, 2'd0, 32'h0000_1234, 0));
      vecs.push_back(mk(1, 1, 5'd5, 32'hCAFE_0005, 0, 0, 3'b000, 2'd0, 2'd0, 32'hCAFE_0005, 1));
      vecs.push_back(mk(1, 1, 5'd6, 32'h0000_0055, 0, 0, 3'b000, 2'd0, 2'd3, 32'h0000_0000, 1));
      vecs.push_back(mk(0, 1, 5'd7, 32'h0000_0077, 0, 0, 3'b000, 2'd0, 2'd0, 32'h0000_0077, 0));
      vecs.push_back(mk(1, 0, 5'd8, 32'h0000_0088, 0, 0, 3'b000, 2'd0, 2'd0, 32'h0000_0088, 0));
      vecs.push_back(mk(1, 1, 5'd31, 32'h1357_9BDF, 0, 0, 3'b000, 2'd0, 2'd0, 32'h1357_9BDF, 1));

      rst_n = 1'b0;
      valid_wb = 0; reg_write_wb = 0; rd_wb = 0; alu_wb = 0; mem_wb = 0;
      pc_wb = 0; funct3_wb = 0; addr_lo_wb = 0; wb_sel = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("por");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

      // Asynchronous reset asserted between edges must clear the bypass state at once.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_state("async_rst");
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // First edge after deassert captures normally; three valid cycles count three.
      apply(mk(1, 1, 5'd14, 32'hA5A5_0001, 0, 0, 3'b000, 2'd0, 2'd0, 32'hA5A5_0001, 1), "post0");
      apply(mk(1, 1, 5'd15, 32'hA5A5_0002, 0, 0, 3'b000, 2'd0, 2'd0, 32'hA5A5_0002, 1), "post1");
      apply(mk(1, 0, 5'd16, 32'hA5A5_0003, 0, 0, 3'b000, 2'd0, 2'd0, 32'hA5A5_0003, 0), "post2");
`ifdef WB_RETIRE_CNT_EN
      check("retired_cnt_after3", retired_cnt, 64'd3);
`endif
      check("sb_empty", 64'(sb_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
